// File: rtl/cordic_sweep_initiator_if.sv
// ---------------------------------------------------------------------------
// cordic_sweep_initiator_if
// Groups the three valid/ready streams of the CORDIC sweep initiator:
//   req_*  : angle/amplitude request to the CORDIC (initiator -> CORDIC)
//   rsp_*  : cos/sin result from the CORDIC        (CORDIC -> initiator)
//   smp_*  : indexed sample output stream          (initiator -> downstream)
// Modports:
//   master : the initiator's view (drives req_*, rsp_ready, smp_*)
//   slave  : the CORDIC/downstream view
// ---------------------------------------------------------------------------
interface cordic_sweep_initiator_if #(
    parameter int unsigned XY_W    = 16,
    parameter int unsigned ANGLE_W = 32,
    parameter int unsigned CNT_W   = 16
);
    logic               req_valid;
    logic               req_ready;
    logic [XY_W-1:0]    req_x;
    logic [XY_W-1:0]    req_y;
    logic [ANGLE_W-1:0] req_z;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [XY_W-1:0]    rsp_cos;
    logic [XY_W-1:0]    rsp_sin;

    logic               smp_valid;
    logic               smp_ready;
    logic [XY_W-1:0]    smp_cos;
    logic [XY_W-1:0]    smp_sin;
    logic [CNT_W-1:0]   smp_idx;
    logic               smp_last;

    modport master (
        output req_valid, req_x, req_y, req_z,
        input  req_ready,
        input  rsp_valid, rsp_cos, rsp_sin,
        output rsp_ready,
        output smp_valid, smp_cos, smp_sin, smp_idx, smp_last,
        input  smp_ready
    );

    modport slave (
        input  req_valid, req_x, req_y, req_z,
        output req_ready,
        output rsp_valid, rsp_cos, rsp_sin,
        input  rsp_ready,
        input  smp_valid, smp_cos, smp_sin, smp_idx, smp_last,
        output smp_ready
    );
endinterface

// File: rtl/cordic_sweep_initiator.sv
// ---------------------------------------------------------------------------
// cordic_sweep_initiator
// Generates a phase sweep (start angle, step, sample count), issues each
// angle with a fixed amplitude to a rotation-mode CORDIC, collects the
// returned cos/sin pairs and re-emits them with a 0-based index and a last
// flag. In-flight CORDIC requests are bounded by a credit counter (MAX_OUT).
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin sweep (sampled only when idle)
//   cfg_phase0/step   : first angle / per-sample increment (mod 2^ANGLE_W)
//   cfg_count/cfg_amp : number of samples / x_start amplitude
//   busy, done        : sweep in progress / one-cycle completion pulse
//   bus (master)      : req_*, rsp_*, smp_* streams
// Optional (macro CORDIC_SWEEP_ABORT_EN):
//   abort             : stop issuing, drain outstanding responses
//   aborted           : high during the done pulse of an aborted sweep
// ---------------------------------------------------------------------------
module cordic_sweep_initiator #(
    parameter int unsigned XY_W    = 16,
    parameter int unsigned ANGLE_W = 32,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned MAX_OUT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ANGLE_W-1:0] cfg_phase0,
    input  logic [ANGLE_W-1:0] cfg_step,
    input  logic [CNT_W-1:0]   cfg_count,
    input  logic [XY_W-1:0]    cfg_amp,
    output logic               busy,
    output logic               done,
`ifdef CORDIC_SWEEP_ABORT_EN
    input  logic               abort,
    output logic               aborted,
`endif
    cordic_sweep_initiator_if.master bus
);
    localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

`ifdef CORDIC_SWEEP_ABORT_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_DRAIN} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

    state_t             state_q, state_d;
    logic [ANGLE_W-1:0] phase_q, phase_d;
    logic [ANGLE_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [XY_W-1:0]    amp_q, amp_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic [CNT_W-1:0]   recv_q, recv_d;
    logic [OUT_W-1:0]   outs_q, outs_d;
    logic               smp_valid_q, smp_valid_d;
    logic [XY_W-1:0]    smp_cos_q, smp_cos_d;
    logic [XY_W-1:0]    smp_sin_q, smp_sin_d;
    logic [CNT_W-1:0]   smp_idx_q, smp_idx_d;
    logic               smp_last_q, smp_last_d;
`ifdef CORDIC_SWEEP_ABORT_EN
    logic               aborted_q, aborted_d;
`endif

    logic req_valid, rsp_ready;
    logic req_hs, rsp_hs, smp_hs;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        step_d      = step_q;
        count_d     = count_q;
        amp_d       = amp_q;
        issued_d    = issued_q;
        recv_d      = recv_q;
        outs_d      = outs_q;
        smp_valid_d = smp_valid_q;
        smp_cos_d   = smp_cos_q;
        smp_sin_d   = smp_sin_q;
        smp_idx_d   = smp_idx_q;
        smp_last_d  = smp_last_q;
`ifdef CORDIC_SWEEP_ABORT_EN
        aborted_d   = aborted_q;
`endif
        req_valid   = 1'b0;
        rsp_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        req_hs      = 1'b0;
        rsp_hs      = 1'b0;
        smp_hs      = smp_valid_q && bus.smp_ready;

        // Delivered sample frees the output register; a same-cycle load
        // below re-arms it.
        if (smp_hs) begin
            smp_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                rsp_ready = 1'b1;   // stray responses are discarded
                if (start) begin
                    phase_d  = cfg_phase0;
                    step_d   = cfg_step;
                    count_d  = cfg_count;
                    amp_d    = cfg_amp;
                    issued_d = '0;
                    recv_d   = '0;
                    outs_d   = '0;
`ifdef CORDIC_SWEEP_ABORT_EN
                    aborted_d = 1'b0;
`endif
                    state_d  = (cfg_count != '0) ? S_RUN : S_DONE;
                end
            end

            S_RUN: begin
                busy      = 1'b1;
                req_valid = (issued_q < count_q) && (outs_q < OUT_W'(MAX_OUT));
`ifdef CORDIC_SWEEP_ABORT_EN
                if (abort) begin
                    req_valid = 1'b0;
                end
`endif
                rsp_ready = !smp_valid_q || bus.smp_ready;
                req_hs    = req_valid && bus.req_ready;
                // A response with nothing outstanding is a protocol error: drop it.
                rsp_hs    = bus.rsp_valid && rsp_ready && (outs_q != '0);

                if (req_hs) begin
                    phase_d  = phase_q + step_q;
                    issued_d = issued_q + 1'b1;
                end
                if (rsp_hs) begin
                    smp_valid_d = 1'b1;
                    smp_cos_d   = bus.rsp_cos;
                    smp_sin_d   = bus.rsp_sin;
                    smp_idx_d   = recv_q;
                    smp_last_d  = (recv_q == count_q - 1'b1);
                    recv_d      = recv_q + 1'b1;
                end
                if (smp_hs && smp_last_q) begin
                    state_d = S_DONE;
                end
`ifdef CORDIC_SWEEP_ABORT_EN
                if (abort) begin
                    state_d   = S_DRAIN;
                    aborted_d = 1'b1;
                end
`endif
            end

`ifdef CORDIC_SWEEP_ABORT_EN
            S_DRAIN: begin
                busy      = 1'b1;
                rsp_ready = 1'b1;
                rsp_hs    = bus.rsp_valid && (outs_q != '0);
                if ((outs_q == '0) && !smp_valid_q) begin
                    state_d = S_DONE;
                end
            end
`endif

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        case ({req_hs, rsp_hs})
            2'b10:   outs_d = outs_q + 1'b1;
            2'b01:   outs_d = outs_q - 1'b1;
            default: outs_d = outs_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            step_q      <= '0;
            count_q     <= '0;
            amp_q       <= '0;
            issued_q    <= '0;
            recv_q      <= '0;
            outs_q      <= '0;
            smp_valid_q <= 1'b0;
            smp_cos_q   <= '0;
            smp_sin_q   <= '0;
            smp_idx_q   <= '0;
            smp_last_q  <= 1'b0;
`ifdef CORDIC_SWEEP_ABORT_EN
            aborted_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            step_q      <= step_d;
            count_q     <= count_d;
            amp_q       <= amp_d;
            issued_q    <= issued_d;
            recv_q      <= recv_d;
            outs_q      <= outs_d;
            smp_valid_q <= smp_valid_d;
            smp_cos_q   <= smp_cos_d;
            smp_sin_q   <= smp_sin_d;
            smp_idx_q   <= smp_idx_d;
            smp_last_q  <= smp_last_d;
`ifdef CORDIC_SWEEP_ABORT_EN
            aborted_q   <= aborted_d;
`endif
        end
    end

    assign bus.req_valid = req_valid;
    assign bus.req_x     = amp_q;
    assign bus.req_y     = '0;
    assign bus.req_z     = phase_q;
    assign bus.rsp_ready = rsp_ready;
    assign bus.smp_valid = smp_valid_q;
    assign bus.smp_cos   = smp_cos_q;
    assign bus.smp_sin   = smp_sin_q;
    assign bus.smp_idx   = smp_idx_q;
    assign bus.smp_last  = smp_last_q;
`ifdef CORDIC_SWEEP_ABORT_EN
    assign aborted = aborted_q && (state_q == S_DONE);
`endif
endmodule

// File: tb/tb_cordic_sweep_initiator.sv
// ---------------------------------------------------------------------------
// tb_cordic_sweep_initiator
// Self-checking bench: a behavioural sweep model (sample k has angle
// phase0 + k*step, index k, last on k == count-1) plus a fake in-order
// CORDIC with fixed latency, checked against the DUT every cycle, and a few
// literal expectations for the directed scenarios.
// ---------------------------------------------------------------------------
module tb_cordic_sweep_initiator;
    localparam int unsigned MAX_OUT = 8;
    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] cfg_phase0, cfg_step;
    logic [15:0] cfg_count, cfg_amp;
    logic        busy, done;
`ifdef CORDIC_SWEEP_ABORT_EN
    logic        aborted_w;
`endif

    cordic_sweep_initiator_if #(.XY_W(16), .ANGLE_W(32), .CNT_W(16)) bus ();

    cordic_sweep_initiator #(.XY_W(16), .ANGLE_W(32), .CNT_W(16), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_phase0(cfg_phase0), .cfg_step(cfg_step),
        .cfg_count(cfg_count), .cfg_amp(cfg_amp),
        .busy(busy), .done(done),
`ifdef CORDIC_SWEEP_ABORT_EN
        .abort(1'b0), .aborted(aborted_w),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Fake CORDIC transfer functions: distinct per angle/amplitude.
    function automatic logic [15:0] fcos(input logic [31:0] z, input logic [15:0] x);
        return x ^ z[31:16] ^ {z[7:0], z[15:8]};
    endfunction
    function automatic logic [15:0] fsin(input logic [31:0] z, input logic [15:0] x);
        return (z[15:0] ^ x) + z[31:16] + 16'h1357;
    endfunction

    // Model state (written only by the compare process)
    logic        rst_e = 1'b0;
    bit          busy_m, done_m;
    int          k, j, rcv, cnt_m, cyc, rsp_total, done_pulses;
    logic [31:0] p0_m, st_m;
    logic [15:0] amp_m;
    logic [31:0] cq_z[$];
    logic [15:0] cq_x[$];
    int          cq_due[$];
    logic [31:0] req_log[$];
    logic [16:0] smp_log[$];

    // Stimulus controls (written only by main)
    bit req_rand, smp_rand, smp_hold;
    int rsp_limit;

    always @(posedge clk) rst_e <= rst;

    // Compare process: checks DUT against the model mid-cycle, then advances
    // the model by the handshakes that will occur at the next edge.
    initial begin
        bit          nb, nd, exp_rv;
        logic [31:0] ze, zj;
        busy_m = 0; done_m = 0; k = 0; j = 0; rcv = 0; cnt_m = 0; cyc = 0;
        rsp_total = 0; done_pulses = 0; p0_m = '0; st_m = '0; amp_m = '0;
        forever begin
            @(negedge clk);
            if (rst_e) begin
                chk("reset_zero",
                    {busy, done, bus.req_valid, bus.smp_valid, bus.smp_last,
                     bus.req_x, bus.req_y, bus.req_z}, '0);
                chk("reset_zero_smp", {bus.smp_cos, bus.smp_sin, bus.smp_idx}, '0);
            end
            if (rst) begin
                busy_m = 0; done_m = 0; k = 0; j = 0; rcv = 0;
                cq_z.delete(); cq_x.delete(); cq_due.delete();
                req_log.delete(); smp_log.delete();
            end else begin
                chk("busy", busy, busy_m);
                chk("done", done, done_m);
                exp_rv = busy_m && (k < cnt_m) && ((k - rcv) < int'(MAX_OUT));
                chk("req_valid", bus.req_valid, exp_rv);
                if (bus.req_valid) begin
                    ze = p0_m + st_m * 32'(k);
                    chk("req_z", bus.req_z, ze);
                    chk("req_x", bus.req_x, amp_m);
                    chk("req_y", bus.req_y, 16'h0);
                end
                if (busy_m) chk("rsp_ready", bus.rsp_ready, !bus.smp_valid || bus.smp_ready);
                chk("smp_valid", bus.smp_valid, busy_m && (rcv > j));
                if (bus.smp_valid) begin
                    zj = p0_m + st_m * 32'(j);
                    chk("smp_idx", bus.smp_idx, 16'(j));
                    chk("smp_last", bus.smp_last, j == cnt_m - 1);
                    chk("smp_cos", bus.smp_cos, fcos(zj, amp_m));
                    chk("smp_sin", bus.smp_sin, fsin(zj, amp_m));
                end

                nb = busy_m; nd = 0;
                if (bus.req_valid && bus.req_ready) begin
                    cq_z.push_back(bus.req_z);
                    cq_x.push_back(bus.req_x);
                    cq_due.push_back(cyc + LAT);
                    req_log.push_back(bus.req_z);
                    k++;
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    rsp_total++;
                    if (busy_m && cq_z.size() > 0) begin
                        void'(cq_z.pop_front()); void'(cq_x.pop_front()); void'(cq_due.pop_front());
                        rcv++;
                    end
                end
                if (bus.smp_valid && bus.smp_ready) begin
                    smp_log.push_back({bus.smp_last, bus.smp_idx});
                    if (j == cnt_m - 1) begin nb = 0; nd = 1; end
                    j++;
                end
                if (start && !busy_m && !done_m) begin
                    p0_m = cfg_phase0; st_m = cfg_step; cnt_m = int'(cfg_count); amp_m = cfg_amp;
                    k = 0; j = 0; rcv = 0;
                    req_log.delete(); smp_log.delete();
                    if (cfg_count != 0) nb = 1; else nd = 1;
                end
                if (done) done_pulses++;
                busy_m = nb; done_m = nd;
            end
            cyc++;
        end
    end

    // CORDIC / downstream driver
    initial begin
        bus.req_ready = 0; bus.smp_ready = 0; bus.rsp_valid = 0;
        bus.rsp_cos = '0; bus.rsp_sin = '0;
        forever begin
            @(posedge clk); #1;
            bus.req_ready = req_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.smp_ready = smp_hold ? 1'b0 : (smp_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (cq_z.size() > 0 && cq_due[0] <= cyc && (rsp_limit < 0 || rsp_total < rsp_limit)) begin
                bus.rsp_valid = 1;
                bus.rsp_cos = fcos(cq_z[0], cq_x[0]);
                bus.rsp_sin = fsin(cq_z[0], cq_x[0]);
            end else begin
                bus.rsp_valid = 0;
                bus.rsp_cos = 16'($urandom);
                bus.rsp_sin = 16'($urandom);
            end
        end
    end

    task automatic start_sweep(input logic [31:0] p0, input logic [31:0] st,
                               input logic [15:0] c, input logic [15:0] a, input bit poke);
        @(posedge clk); #1;
        cfg_phase0 = p0; cfg_step = st; cfg_count = c; cfg_amp = a; start = 1;
        @(posedge clk); #1;
        start = 0;
        // Inputs are latched at start; scrambling them must not matter.
        cfg_phase0 = $urandom; cfg_step = $urandom; cfg_count = 16'($urandom); cfg_amp = 16'($urandom);
        if (poke) begin
            repeat (2) @(posedge clk);
            #1 start = 1;
            @(posedge clk); #1 start = 0;
        end
    endtask

    task automatic wait_done(input int dp, input int budget, input string name);
        for (int i = 0; i < budget && done_pulses == dp; i++) @(posedge clk);
        @(posedge clk); #1;
        chk(name, done_pulses - dp, 1);
    endtask

    task automatic run_sweep(input logic [31:0] p0, input logic [31:0] st,
                             input logic [15:0] c, input logic [15:0] a, input bit poke);
        int dp;
        dp = done_pulses;
        start_sweep(p0, st, c, a, poke);
        wait_done(dp, 400, "sweep_done");
    endtask

    initial begin
        logic [31:0] exp_basic[4];
        logic [31:0] exp_wrap[3];
        int dp;
        exp_basic = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
        exp_wrap  = '{32'hF000_0000, 32'h1000_0000, 32'h3000_0000};
        rst = 1; start = 0; cfg_phase0 = '0; cfg_step = '0; cfg_count = '0; cfg_amp = '0;
        req_rand = 0; smp_rand = 0; smp_hold = 0; rsp_limit = -1;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Basic sweep
        run_sweep(32'h0, 32'h4000_0000, 16'd4, 16'h4000, 0);
        chk("basic_nreq", req_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < req_log.size()) chk("basic_z", req_log[i], exp_basic[i]);
        chk("basic_nsmp", smp_log.size(), 4);
        if (smp_log.size() == 4) begin
            chk("basic_first", smp_log[0], 17'h0_0000);
            chk("basic_last", smp_log[3], 17'h1_0003);
        end

        // Zero count
        run_sweep(32'h1234_5678, 32'h1, 16'd0, 16'h7FFF, 0);
        chk("zero_nreq", req_log.size(), 0);

        // Credit limit
        rsp_limit = rsp_total;
        dp = done_pulses;
        start_sweep(32'h0, 32'h0100_0000, 16'd20, 16'h1111, 0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("credit_8", req_log.size(), 8);
        chk("credit_rv", bus.req_valid, 0);
        rsp_limit = rsp_total + 1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("credit_9", req_log.size(), 9);
        chk("credit_rv2", bus.req_valid, 0);
        rsp_limit = -1;
        wait_done(dp, 400, "credit_done");

        // Output backpressure
        dp = done_pulses;
        start_sweep(32'h0ABC_0000, 32'h0123_4567, 16'd16, 16'h2222, 0);
        for (int i = 0; i < 200 && j < 3; i++) @(posedge clk);
        @(posedge clk);
        smp_hold = 1;
        repeat (3) @(negedge clk);
        chk("bp_valid", bus.smp_valid, 1);
        chk("bp_rsp_ready", bus.rsp_ready, 0);
        repeat (7) @(posedge clk);
        smp_hold = 0;
        wait_done(dp, 400, "bp_done");
        chk("bp_nsmp", smp_log.size(), 16);

        // Phase wrap
        run_sweep(32'hF000_0000, 32'h2000_0000, 16'd3, 16'h0100, 0);
        chk("wrap_nreq", req_log.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < req_log.size()) chk("wrap_z", req_log[i], exp_wrap[i]);

        // Randomised sweeps with ready jitter and start pokes while busy
        req_rand = 1; smp_rand = 1;
        for (int n = 0; n < 8; n++) begin
            logic [15:0] c;
            c = 16'($urandom_range(1, 12));
            run_sweep($urandom, $urandom, c, 16'($urandom), c >= 6);
            chk("rand_nsmp", smp_log.size(), c);
        end
        req_rand = 0; smp_rand = 0;

        // Reset mid-run with requests outstanding
        rsp_limit = rsp_total;
        start_sweep(32'h5555_0000, 32'h0010_0000, 16'd10, 16'h3333, 0);
        for (int i = 0; i < 50 && req_log.size() < 3; i++) @(posedge clk);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_reqv", bus.req_valid, 0);
        @(posedge clk); #1 rst = 0;
        rsp_limit = -1;
        run_sweep(32'h0, 32'h1000_0000, 16'd5, 16'h0123, 0);
        chk("midrst_nsmp", smp_log.size(), 5);
        if (smp_log.size() > 0) chk("midrst_first", smp_log[0], 17'h0_0000);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule
